// File: rtl/key_repeat.sv
// key_repeat: synchronised, debounced direction buttons with typematic auto-repeat, timed via an external ms-delay timer.
// Optional build macro KEY_REPEAT_ACCEL_EN: the repeat interval shrinks by ACCEL_STEP_MS per repeat, floored at MIN_REPEAT_MS.
module key_repeat #(
    parameter logic [7:0] DEBOUNCE_MS   = 8'd20,
    parameter logic [7:0] FIRST_MS      = 8'd250,
    parameter logic [7:0] REPEAT_MS     = 8'd100
`ifdef KEY_REPEAT_ACCEL_EN
    ,
    parameter logic [7:0] ACCEL_STEP_MS = 8'd10,
    parameter logic [7:0] MIN_REPEAT_MS = 8'd40
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       dly_free,
    output logic       dly_set,
    output logic [7:0] dly_ms,
    output logic       move,
    output logic [1:0] dir,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, FIRST, REPEAT} state_t;

    state_t     state_q, state_d;
    logic [3:0] btn_meta_q, btn_s_q;
    logic [1:0] dir_q, dir_d, sel;
    logic       move_q, move_d;
    logic       dly_set_q, dly_set_d;
    logic [7:0] dly_ms_q, dly_ms_d;
    logic       busy_q, busy_d;
    logic [7:0] rep_ms;
    logic       held, expired;

`ifdef KEY_REPEAT_ACCEL_EN
    logic [7:0] rep_ms_q, rep_ms_d, rep_ms_dec;

    // Saturating step: compare in 9 bits so MIN + STEP cannot wrap.
    assign rep_ms_dec = ({1'b0, rep_ms_q} >= ({1'b0, MIN_REPEAT_MS} + {1'b0, ACCEL_STEP_MS}))
                      ? rep_ms_q - ACCEL_STEP_MS : MIN_REPEAT_MS;
    assign rep_ms     = rep_ms_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rep_ms_q <= REPEAT_MS;
        else      rep_ms_q <= rep_ms_d;
    end
`else
    assign rep_ms = REPEAT_MS;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_q <= '0;
            btn_s_q    <= '0;
        end else begin
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
        end
    end

    always_comb begin
        sel = 2'd3;
        if      (btn_s_q[0]) sel = 2'd0;
        else if (btn_s_q[1]) sel = 2'd1;
        else if (btn_s_q[2]) sel = 2'd2;
    end

    // The timer still reports the previous expiry while it is being loaded.
    assign held    = btn_s_q[dir_q];
    assign expired = dly_free && !dly_set_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        dir_d     = dir_q;
        move_d    = 1'b0;
        dly_set_d = 1'b0;
        dly_ms_d  = dly_ms_q;
`ifdef KEY_REPEAT_ACCEL_EN
        rep_ms_d  = rep_ms_q;
`endif
        case (state_q)
            IDLE: begin
                if (|btn_s_q) begin
                    dir_d     = sel;
                    dly_set_d = 1'b1;
                    dly_ms_d  = DEBOUNCE_MS;
                    state_d   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (expired) begin
                    move_d    = 1'b1;
                    dly_set_d = 1'b1;
                    dly_ms_d  = FIRST_MS;
                    state_d   = FIRST;
`ifdef KEY_REPEAT_ACCEL_EN
                    rep_ms_d  = REPEAT_MS;
`endif
                end
            end
            FIRST, REPEAT: begin
                if (!held) begin
                    state_d = IDLE;
                end else if (expired) begin
                    move_d    = 1'b1;
                    dly_set_d = 1'b1;
                    dly_ms_d  = rep_ms;
                    state_d   = REPEAT;
`ifdef KEY_REPEAT_ACCEL_EN
                    rep_ms_d  = rep_ms_dec;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            dir_q     <= 2'd0;
            move_q    <= 1'b0;
            dly_set_q <= 1'b0;
            dly_ms_q  <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            move_q    <= move_d;
            dly_set_q <= dly_set_d;
            dly_ms_q  <= dly_ms_d;
            busy_q    <= busy_d;
        end
    end

    assign dly_set = dly_set_q;
    assign dly_ms  = dly_ms_q;
    assign move    = move_q;
    assign dir     = dir_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat: random button episodes on two key_repeat instances (default debounce and zero debounce),
// each with a behavioural ms timer (one clock per ms); an episode-level model feeds per-instance scoreboards.
module tb_key_repeat;

    localparam int DEB_MS    = 20;
    localparam int FIRST_MS  = 250;
    localparam int REPEAT_MS = 100;

    typedef struct {
        int cyc;
        bit move;
        bit set;
        int ms;
        int dir;
        bit busy;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       free0, set0, move0, busy0;
    logic       free1, set1, move1, busy1;
    logic [7:0] ms0, ms1;
    logic [1:0] dir0, dir1;
    int         cnt0, cnt1;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    bit         busy_prev [2];
    ev_t        exp0 [$];
    ev_t        exp1 [$];

    key_repeat u_dut (
        .clk(clk), .rst(rst), .btn(btn), .dly_free(free0), .dly_set(set0),
        .dly_ms(ms0), .move(move0), .dir(dir0), .busy(busy0)
    );

    key_repeat #(.DEBOUNCE_MS(8'd0)) u_dut_d0 (
        .clk(clk), .rst(rst), .btn(btn), .dly_free(free1), .dly_set(set1),
        .dly_ms(ms1), .move(move1), .dir(dir1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Delay timers: load on set, count down one per clock, free while zero; cleared by the shared reset.
    always @(posedge clk or negedge rst) begin
        if (!rst)              cnt0 <= 0;
        else if (set0)         cnt0 <= int'(ms0);
        else if (cnt0 != 0)    cnt0 <= cnt0 - 1;
    end
    always @(posedge clk or negedge rst) begin
        if (!rst)              cnt1 <= 0;
        else if (set1)         cnt1 <= int'(ms1);
        else if (cnt1 != 0)    cnt1 <= cnt1 - 1;
    end
    assign free0 = (cnt0 == 0);
    assign free1 = (cnt1 == 0);

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int prio(input logic [3:0] p);
        for (int i = 0; i < 4; i++)
            if (p[i]) return i;
        return 0;
    endfunction

    task automatic push(input int k, input ev_t ev);
        if (k == 0) exp0.push_back(ev);
        else        exp1.push_back(ev);
    endtask

    // One hold of direction d: FSM sees the press at edge e and the release at edge rel.
    // A wait of m ms started at edge s ends (free sampled) at edge s + m + 2.
    task automatic expect_press(input int k, input int d, input int e, input int rel);
        int deb, t, ms, rep;
        deb = (k == 0) ? DEB_MS : 0;
        push(k, '{e, 1'b0, 1'b1, deb, d, 1'b1});
        t   = e + deb + 2;
        ms  = FIRST_MS;
        rep = REPEAT_MS;
        while (t < rel) begin
            push(k, '{t, 1'b1, 1'b1, ms, d, 1'b1});
            t  = t + ms + 2;
            ms = rep;
`ifdef KEY_REPEAT_ACCEL_EN
            rep = (rep - 10 >= 40) ? rep - 10 : 40;
`endif
        end
        push(k, '{rel, 1'b0, 1'b0, 0, d, 1'b0});
    endtask

    // Hold p for h1 cycles, then drop only the winning button for h2 cycles, then all off for g cycles.
    task automatic run_episode(input logic [3:0] p, input int h1, input int h2, input int g);
        int         e0, d;
        logic [3:0] p2;
        e0 = cyc + 1;
        d  = prio(p);
        p2 = p & ~(4'b0001 << d);
        for (int k = 0; k < 2; k++) begin
            expect_press(k, d, e0 + 2, e0 + h1 + 2);
            if (p2 != 4'b0 && h2 >= 2)
                expect_press(k, prio(p2), e0 + h1 + 3, e0 + h1 + h2 + 2);
        end
        btn = p;
        repeat (h1) @(negedge clk);
        if (h2 > 0) begin
            btn = p2;
            repeat (h2) @(negedge clk);
        end
        btn = 4'b0;
        repeat (g) @(negedge clk);
    endtask

    task automatic mon_step(input int k, input logic mv, input logic st, input logic [7:0] ms,
                            input logic [1:0] dr, input logic bsy);
        ev_t ev;
        bit  fire, have;
        fire = mv || st || (bsy != busy_prev[k]);
        busy_prev[k] = bsy;
        if (!fire) return;
        have = (k == 0) ? (exp0.size() != 0) : (exp1.size() != 0);
        if (!have) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_event[%0d]: got move=%0b set=%0b busy=%0b at cycle %0d, expected no event",
                     k, mv, st, bsy, cyc);
            return;
        end
        if (k == 0) ev = exp0.pop_front();
        else        ev = exp1.pop_front();
        check($sformatf("event_cycle[%0d]", k), cyc, ev.cyc);
        check($sformatf("move[%0d]", k), int'(mv), int'(ev.move));
        check($sformatf("dly_set[%0d]", k), int'(st), int'(ev.set));
        check($sformatf("dir[%0d]", k), int'(dr), ev.dir);
        check($sformatf("busy[%0d]", k), int'(bsy), int'(ev.busy));
        if (ev.set) check($sformatf("dly_ms[%0d]", k), int'(ms), ev.ms);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, move0, set0, ms0, dir0, busy0);
            mon_step(1, move1, set1, ms1, dir1, busy1);
        end
    end

    initial begin
        logic [3:0] p;
        int         h1, h2, g;
        rst = 1'b0;
        btn = 4'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            check("reset_outputs0", int'({move0, set0, dir0, busy0, ms0}), 0);
            check("reset_outputs1", int'({move1, set1, dir1, busy1, ms1}), 0);
        end
        btn = 4'b0;
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_after_reset0", int'(busy0), 0);
        check("idle_after_reset1", int'(busy1), 0);

        run_episode(4'b0001, 100, 0, 8);   // single tap
        run_episode(4'b0100, 10, 0, 8);    // bounce shorter than debounce
        run_episode(4'b1000, 500, 0, 8);   // first move plus three repeats
        run_episode(4'b0011, 40, 0, 8);    // up beats down
        run_episode(4'b0010, 22, 0, 8);    // release on the debounce expiry edge
        run_episode(4'b0010, 2, 0, 8);     // same for the zero-debounce instance
        run_episode(4'b0101, 60, 80, 8);   // re-arm on the button still held
        run_episode(4'b1100, 300, 1, 5);   // remaining button seen for one cycle only
`ifdef KEY_REPEAT_ACCEL_EN
        run_episode(4'b0001, 1200, 0, 8);  // long hold walks the interval down to the floor
        run_episode(4'b0001, 500, 0, 8);   // re-press restarts at the initial interval
`endif

        for (int i = 0; i < 40; i++) begin
            p  = 4'($urandom_range(15, 1));
            h1 = ($urandom_range(1, 0) == 1) ? int'($urandom_range(30, 1)) : int'($urandom_range(700, 200));
            h2 = int'($urandom_range(60, 0));
            g  = int'($urandom_range(12, 1));
            run_episode(p, h1, h2, g);
        end

        repeat (20) @(negedge clk);
        check("pending_events0", exp0.size(), 0);
        check("pending_events1", exp1.size(), 0);
        check("final_busy0", int'(busy0), 0);
        check("final_busy1", int'(busy1), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/key_repeat.md
Name: key_repeat

Overview:
- Direction-button front end for the maze player.
- Synchronises four raw buttons, debounces the press, and emits one-cycle move pulses with typematic auto-repeat.
- All timing comes from the downstream ms-delay timer, driven via dly_set/dly_ms and monitored via dly_free.
- Sits between board buttons and the player-position logic; the top level ties the timer's active-high reset to ~rst.

Parameters:
- DEBOUNCE_MS, 8'd20, settle time before the first move is accepted.
- FIRST_MS, 8'd250, hold time from the first move to the first repeat.
- REPEAT_MS, 8'd100, interval between repeats (start value when the accel feature is enabled).
- ACCEL_STEP_MS, 8'd10, decrement per repeat (accel feature only).
- MIN_REPEAT_MS, 8'd40, floor for the repeat interval (accel feature only).

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- btn, in, 4, raw buttons {right,left,down,up}, active-high, asynchronous to clk.
- dly_free, in, 1, timer idle flag from the delay timer.
- dly_set, out, 1, one-cycle load strobe to the delay timer.
- dly_ms, out, 8, delay value, valid while dly_set=1.
- move, out, 1, one-cycle move pulse.
- dir, out, 2, direction of the current/last press: 0 up, 1 down, 2 left, 3 right.
- busy, out, 1, high whenever state != IDLE.

Behaviour:
- Reset: when rst=0, all flops clear asynchronously: synchroniser, state=IDLE, move=0, dir=0, dly_set=0, dly_ms=0, busy=0.
- Synchroniser: two-flop synchroniser on each btn bit gives btn_s; btn changes reach btn_s after 2 clk edges.
- Priority encode of btn_s: up > down > left > right. btn_s!=0 flags a press; sel is the encoded direction.
- All outputs are registered. dly_set and move are single-cycle pulses.
- Stale-free guard: dly_free is ignored in any cycle where dly_set=1. The timer only drops free on the edge after it sees set.
- A delay value of 0 is legal: free stays high, so the wait ends the cycle after dly_set.
- FSM states: IDLE, DEBOUNCE, FIRST, REPEAT.
- IDLE, btn_s!=0: latch dir<=sel, pulse dly_set with dly_ms=DEBOUNCE_MS, go to DEBOUNCE. No move pulse yet.
- DEBOUNCE, btn_s[dir]=0 at any cycle: go to IDLE; no pulse; the timer is left running and ignored.
- DEBOUNCE, guard satisfied and dly_free=1, button still held: pulse move, pulse dly_set with FIRST_MS, go to FIRST. move and dly_set assert in the same cycle.
- FIRST, btn_s[dir]=0: go to IDLE immediately.
- FIRST, guard satisfied and dly_free=1: pulse move, pulse dly_set with the current repeat interval, go to REPEAT.
- REPEAT, btn_s[dir]=0: go to IDLE immediately.
- REPEAT, guard satisfied and dly_free=1: pulse move, reload the timer with the current repeat interval, stay in REPEAT.
- Release has priority over dly_free in the same cycle: no move pulse, go to IDLE.
- Other buttons pressed while holding dir are ignored. After dir is released, IDLE re-arms on the next cycle if another button is still down, with a full debounce.
- dir holds its value in IDLE; it changes only on IDLE exit.
- Reset mid-operation: the FSM returns to IDLE. The timer is cleared by the shared reset, so no stale free can occur.

Optional Feature:
- Macro: KEY_REPEAT_ACCEL_EN.
- Defined: an 8-bit register rep_ms is loaded with REPEAT_MS on entry to FIRST.
  - Each REPEAT reload uses rep_ms, then sets rep_ms <= max(rep_ms - ACCEL_STEP_MS, MIN_REPEAT_MS).
  - The subtraction saturates; it never wraps below MIN_REPEAT_MS.
  - rep_ms resets to REPEAT_MS.
- Not defined: every repeat uses REPEAT_MS; rep_ms and its logic are not synthesised.

Test Plan:
- Reset: hold rst=0 with btn=4'b0001 toggling -> move=0, dly_set=0, dir=0, busy=0; after release, the FSM stays in IDLE until btn_s is nonzero.
- Single tap: btn=0001 held past the debounce, released before FIRST_MS expires -> exactly one move with dir=0; dly_set pulses with dly_ms=20 then 250; busy drops the cycle after btn_s falls.
- Bounce: btn=0100 for less than the debounce time, then 0 -> zero move pulses, return to IDLE, exactly one dly_set (ms=20).
- Auto-repeat: btn=1000 held through the first and three repeat expiries -> 4 moves, dir=3; dly_ms sequence 20,250,100,100,100; no move in any cycle where dly_set was high without a free-sampled expiry.
- Edge cases:
  - DEBOUNCE_MS=0 -> move appears on the second cycle after entering DEBOUNCE.
  - btn=0011 -> dir=0 (up wins).
  - Release in the same cycle dly_free rises -> no move.
- Accel (KEY_REPEAT_ACCEL_EN): hold for 8 repeats -> dly_ms sequence 100,90,80,70,60,50,40,40; re-press resets the sequence to start at 100.
